pixel_line_fifo: RTL

Elastic pixel buffer between the QSPI DTR flash reader and the RGB output registers. It absorbs the bursty `pixel_valid` byte stream from flash and releases one byte per `REPEAT` active display clocks, which gives horizontal pixel doubling. Each released byte is converted to registered RGB222, with optional ordered dither. It flags under-run and over-run per line so that flash timing can be checked on silicon.

---
 rtl/pixel_line_fifo.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pixel_line_fifo.sv
// pixel_line_fifo
// Elastic byte buffer between the flash reader and the RGB output registers.
// Bytes arrive in bursts on in_valid and leave one per REPEAT active display
// clocks (horizontal pixel doubling). Each released byte is converted from
// RGB332 to a registered RGB222 value. Per-line sticky flags record under-run
// and over-run so flash timing can be checked on silicon.
//
// Build option: define PIXEL_FIFO_DITHER_EN to replace plain truncation of the
// R and G channels with a 2x2 ordered dither driven by col0/row0.

module pixel_line_fifo #(
    parameter int DEPTH  = 4,   // FIFO entries, power of two, 2..16
    parameter int REPEAT = 2    // display clocks per source byte, 1..4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    input  logic                       line_start,
    input  logic                       active,
    input  logic                       col0,
    input  logic                       row0,
    output logic [5:0]                 out_rgb,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       almost_full,
    output logic                       underflow,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [RW-1:0] rep;
    logic [7:0]    cur;

    logic          pop_req;
    logic          pop_ok;
    logic          push_ok;
    logic          fifo_empty;
    logic          fifo_full;
    logic [7:0]    cur_nxt;
    logic [1:0]    conv_r;
    logic [1:0]    conv_g;
    logic [1:0]    conv_b;

    // Occupancy flags derived from the level counter.
    assign fifo_empty  = (level == '0);
    assign fifo_full   = (level == LW'(DEPTH));
    assign almost_full = (level >= LW'(DEPTH - 1));

    // Pop/push qualification; line_start suppresses both for its cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pop_req = 1'b0;
        pop_ok  = 1'b0;
        push_ok = 1'b0;
        cur_nxt = cur;
        if (!line_start) begin
            pop_req = active && (rep == '0);
            pop_ok  = pop_req && !fifo_empty;
            // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
            push_ok = in_valid && (!fifo_full || pop_ok);
            if (pop_ok) begin
                cur_nxt = mem[rd_ptr];
            end
        end
    end

`ifdef PIXEL_FIFO_DITHER_EN
    // Add the dither bit before halving; 4-bit sum keeps 7+1 from wrapping, then clamp to 3.
    function automatic logic [1:0] dither_chan(input logic [2:0] v, input logic d);
        logic [3:0] s;
        s = ({1'b0, v} + {3'b000, d}) >> 1;
        return (s > 4'd3) ? 2'd3 : s[1:0];
    endfunction

    // Ordered-dither RGB332 -> RGB222 conversion of the next current pixel.
    always_comb begin
        conv_r = dither_chan(cur_nxt[2:0], row0 ^ col0);
        conv_g = dither_chan(cur_nxt[5:3], row0 ^ col0);
        conv_b = cur_nxt[7:6];
    end
`else
    logic unused_dither;
    assign unused_dither = col0 ^ row0;

    // Truncating RGB332 -> RGB222 conversion of the next current pixel.
    always_comb begin
        conv_r = cur_nxt[2:1];
        conv_g = cur_nxt[5:4];
        conv_b = cur_nxt[7:6];
    end
`endif

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the data array has no reset; pointers and level define which entries are live.
        if (push_ok) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, level, repeat counter, current pixel, flags and registered colour.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            rep       <= '0;
            cur       <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            out_rgb   <= '0;
        end else if (line_start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            rep       <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            out_rgb   <= active ? {conv_r, conv_g, conv_b} : 6'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cur <= cur_nxt;

            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            if (pop_req && fifo_empty) begin
                underflow <= 1'b1;
            end
            if (in_valid && !push_ok) begin
                overflow <= 1'b1;
            end

            if (!active || rep == RW'(REPEAT - 1)) begin
                rep <= '0;
            end else begin
                rep <= rep + RW'(1);
            end

            out_rgb <= active ? {conv_r, conv_g, conv_b} : 6'd0;
        end
    end

endmodule
